i2s_tx: RTL

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/i2s_pkg.sv | 10 +
 rtl/i2s_clkgen.sv | 55 +++++
 rtl/i2s_tx.sv | 90 +++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions used by both the transmitter and the receiver.
// Channel numbering follows the word-select level: left = 0, right = 1.
package i2s_pkg;

  localparam int TIDW = 8;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_clkgen.sv
// Bit/word clock generator: divides clk into sclk and walks the 2*SW-bit frame.
// Emits a fall tick (sclk falling) and a slot-start strobe with its channel.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int SW  = 32,
  parameter int DIV = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       sclk,
  output logic                       lrclk,
  output logic                       tick,
  output logic                       slot_start,
  output logic                       slot_ch,
  output logic [$clog2(2*SW)-1:0]    bit_next
);

  localparam int DCW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int BCW = $clog2(2*SW);

  logic [DCW-1:0] div_ctr;
  logic [DCW-1:0] div_next;
  logic [BCW-1:0] bit_ctr;
  logic           prime;

  // prime stands in for the missing "tick into bit 0" right after reset, so
  // the first left slot is started (and underruns) like any other slot.
  always_comb begin
    tick       = (div_ctr == DCW'(DIV - 1));
    div_next   = tick ? '0 : div_ctr + 1'b1;
    bit_next   = (bit_ctr == BCW'(2*SW - 1)) ? '0 : bit_ctr + 1'b1;
    slot_start = prime || (tick && ((bit_next == '0) || (bit_next == BCW'(SW))));
    slot_ch    = (!prime && (bit_next >= BCW'(SW))) ? CH_RIGHT : CH_LEFT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_ctr <= '0;
      bit_ctr <= '0;
      sclk    <= 1'b0;
      lrclk   <= 1'b0;
      prime   <= 1'b1;
    end else begin
      prime   <= 1'b0;
      div_ctr <= div_next;
      sclk    <= (div_next >= DCW'(DIV/2));
      if (tick) begin
        bit_ctr <= bit_next;
        lrclk   <= (bit_next >= BCW'(SW));
      end
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one holding register per channel fed from an AXI-stream
// sink, serialised MSB first with the standard one-bit delay after lrclk.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int DW  = 24,
  parameter int SW  = 32,
  parameter int DIV = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   s_axis_tdata,
  input  logic            s_axis_tvalid,
  output logic            s_axis_tready,
  input  logic [TIDW-1:0] s_axis_tid,
  output logic            sclk,
  output logic            lrclk,
  output logic            sdo,
  output logic            underrun
);

  localparam int BCW = $clog2(2*SW);

  logic           tick;
  logic           slot_start;
  logic           slot_ch;
  logic [BCW-1:0] bit_next;
  logic [BCW-1:0] k_next;
  logic           in_ch;
  logic           accept;
  logic           unused_tid;
  logic [DW-1:0]  hold [2];
  logic [1:0]     full;
  logic [DW-1:0]  shreg;

  i2s_clkgen #(.SW(SW), .DIV(DIV)) u_clkgen (
    .clk        (clk),
    .rst        (rst),
    .sclk       (sclk),
    .lrclk      (lrclk),
    .tick       (tick),
    .slot_start (slot_start),
    .slot_ch    (slot_ch),
    .bit_next   (bit_next)
  );

  assign in_ch      = s_axis_tid[0];
  assign unused_tid = ^s_axis_tid[TIDW-1:1];

  // Handshake: a beat transfers on any clk where tvalid && tready; tready is
  // high exactly when the holding register of the addressed channel is empty
  // and does not depend on tvalid.
  always_comb begin
    s_axis_tready = !full[in_ch];
    accept        = s_axis_tvalid && s_axis_tready;
    k_next        = (bit_next >= BCW'(SW)) ? bit_next - BCW'(SW) : bit_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full     <= '0;
      hold[0]  <= '0;
      hold[1]  <= '0;
      shreg    <= '0;
      sdo      <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (accept) hold[in_ch] <= s_axis_tdata;
      // A same-clk accept wins over the load clear: the load saw the old state.
      for (int c = 0; c < 2; c++) begin
        if (accept && (in_ch == 1'(c)))               full[c] <= 1'b1;
        else if (slot_start && (slot_ch == 1'(c)))    full[c] <= 1'b0;
      end
      if (slot_start) begin
        shreg    <= full[slot_ch] ? hold[slot_ch] : '0;
        underrun <= !full[slot_ch];
      end
      if (tick) begin
        if ((k_next >= BCW'(1)) && (k_next <= BCW'(DW))) begin
          sdo   <= shreg[DW-1];
          shreg <= shreg << 1;
        end else begin
          sdo <= 1'b0;
        end
      end
    end
  end

endmodule
